// File: rtl/board_io_pkg.sv
// Shared encodings for the switch/LED/button board front end.
// State and display-select values are visible to the harness via ports.
package board_io_pkg;

  typedef enum logic [1:0] {
    S_OP    = 2'd0,
    S_A     = 2'd1,
    S_B     = 2'd2,
    S_READY = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_SW = 2'd0,
    SEL_OP = 2'd1,
    SEL_A  = 2'd2,
    SEL_B  = 2'd3
  } sel_t;

  localparam int BTN_CAP  = 0;
  localparam int BTN_CLR  = 1;
  localparam int BTN_DISP = 2;

endpackage

// File: rtl/btn_debounce.sv
// One push button: 2-FF synchronizer, stability counter, debounced level
// and a single-cycle press pulse on each accepted rising level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Any cycle where synced and level agree restarts the count, so bounce
  // never accumulates toward a level change.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/operand_loader.sv
// Board input front end: debounced buttons step a capture FSM that latches
// op/opa/opb from the switches and strobes go; leds echo a selected field.
module operand_loader
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw,
  input  logic [3:0] btn,
  output logic [3:0] op,
  output logic [3:0] opa,
  output logic [3:0] opb,
  output logic       go,
  output logic [1:0] state,
  output logic [3:0] led
);

  // go acts as a valid with no ready: op/opa/opb are valid in any cycle
  // go is high, and the consumer must accept it in that same cycle.

  logic [3:0] press;
  logic       unused_press3;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (btn[i]),
      .press (press[i])
    );
  end

  assign unused_press3 = press[3];

  state_t     state_q, state_d;
  sel_t       sel_q;
  logic [3:0] op_d, opa_d, opb_d;
  logic       go_d;
  logic       cap, clr;

  assign cap = press[BTN_CAP];
  assign clr = press[BTN_CLR];

  // Clear outranks a capture arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    op_d    = op;
    opa_d   = opa;
    opb_d   = opb;
    go_d    = 1'b0;
    if (clr) begin
      state_d = S_OP;
      op_d    = '0;
      opa_d   = '0;
      opb_d   = '0;
    end else if (cap) begin
      case (state_q)
        S_OP: begin
          op_d    = sw;
          state_d = S_A;
        end
        S_A: begin
          opa_d   = sw;
          state_d = S_B;
        end
        S_B: begin
          opb_d   = sw;
          state_d = S_READY;
          go_d    = 1'b1;
        end
        default: begin
          go_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_OP;
      op      <= '0;
      opa     <= '0;
      opb     <= '0;
      go      <= 1'b0;
      sel_q   <= SEL_SW;
      led     <= '0;
    end else begin
      state_q <= state_d;
      op      <= op_d;
      opa     <= opa_d;
      opb     <= opb_d;
      go      <= go_d;
      if (press[BTN_DISP]) sel_q <= sel_t'(sel_q + 2'd1);
      case (sel_q)
        SEL_SW:  led <= sw;
        SEL_OP:  led <= op;
        SEL_A:   led <= opa;
        default: led <= opb;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: doc/operand_loader.md
# operand_loader

Board-side input front end for the ALU lab: it debounces the four push buttons and walks a small state machine that latches the switch value into an opcode register and two operand registers in turn. It then issues a one-cycle `go` strobe to the ALU under test. The four LEDs echo either the live switches or any captured field. It is the reading end of the switch/LED board interface: switches are data, buttons are commands, LEDs are the operator's confirmation.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples required to accept a button level change; must be ≥1. The board build overrides it, for example to 1_000_000.
- `clk` input, 1: system clock; all logic is on the rising edge.
- `reset` input, 1: synchronous, active-high reset.
- `sw` input, 4: raw switch value, the data to capture; not debounced.
- `btn` input, 4: raw buttons. `btn[0]` = capture/advance, `btn[1]` = clear, `btn[2]` = cycle display, `btn[3]` = reserved and ignored.
- `op` output, 4: captured opcode.
- `opa` output, 4: captured operand A.
- `opb` output, 4: captured operand B.
- `go` output, 1: one-cycle strobe; operands are valid whenever it is high.
- `state` output, 2: current FSM state, for the test harness.
- `led` output, 4: registered display value.

## Operation
- **Input path:** each `btn[i]` passes through a 2-FF synchronizer, then a per-button debounce counter.
  - The counter increments while the synced value differs from the debounced level and clears to 0 on any cycle where they match, so any bounce restarts the count.
  - When the count reaches `DEBOUNCE_CYCLES`, the debounced level takes the synced value and the counter clears.
  - A press pulse is the debounced level ANDed with NOT its previous-cycle value; it lasts one cycle per press, and releases produce no pulse.
- **FSM states:** `S_OP`=0, `S_A`=1, `S_B`=2, `S_READY`=3. The transitions below act on a `btn[0]` press.
  - `S_OP`: `op`←`sw`, go to `S_A`.
  - `S_A`: `opa`←`sw`, go to `S_B`.
  - `S_B`: `opb`←`sw`, go to `S_READY`, `go`=1 for one cycle.
  - `S_READY`: stay in `S_READY`, `go`=1 for one cycle (re-fire with the same operands).
- **Clear:** a `btn[1]` press in any state sets `op`/`opa`/`opb`←0, returns to `S_OP`, and keeps `go`=0.
  - Clear has priority over a simultaneous capture.
  - The display select is not affected.
- **Display select:** a 2-bit `sel`, incremented by each `btn[2]` press and wrapping 3→0.
  - `led` each cycle takes: `sel`=0 → `sw`; 1 → `op`; 2 → `opa`; 3 → `opb`.
  - `btn[2]` is independent of `btn[0]`/`btn[1]`; simultaneous presses are each applied.
- **Width rules:** all data fields are 4 bits. `sw` is sampled unsynchronized at the capture edge; the operator is required to hold switches static while pressing.

## Timing
- **Reset:** all outputs are 0 (`op`, `opa`, `opb`, `go`, `led`, `state`=`S_OP`). Synchronizers, debounced levels, counters and `sel` are also 0.
- **Mid-operation reset:** any partially captured fields are discarded. A button held through reset is seen as a fresh press once debounced after reset deasserts.
- **Press latency:** take edge 0 as the first edge that samples raw `btn` high, stable from then on.
  - The debounced level rises at edge 1+`DEBOUNCE_CYCLES`.
  - The press pulse is high during the following cycle.
  - FSM, field registers, `go` and `sel` update at edge 2+`DEBOUNCE_CYCLES`.
- **`led`:** registered, 1 cycle behind the mux inputs.
  - With `sel`=0 it follows `sw` with 1-cycle latency.
  - After a capture, it shows the new field 1 cycle after the field register updates.
- **`go`:** registered; exactly 1 cycle wide per accepted press; never high on consecutive cycles unless the pulses come from separate presses.
- **Repeated presses:** the next press needs a release followed by a re-press, each held for ≥`DEBOUNCE_CYCLES`+2 cycles.

## Structure
- **Shared package `board_io_pkg`:**
  - state encoding constants `S_OP`/`S_A`/`S_B`/`S_READY`;
  - display select constants `SEL_SW`/`SEL_OP`/`SEL_A`/`SEL_B`;
  - button index constants `BTN_CAP`=0, `BTN_CLR`=1, `BTN_DISP`=2.
- **Sub-module `btn_debounce`:** one button, parameter `DEBOUNCE_CYCLES`; contains the synchronizer, counter, level and press pulse. Instantiated 4 times via generate; the `btn[3]` instance's press output is left unused.
- **Counter width:** `$clog2(DEBOUNCE_CYCLES+1)`.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4.
- **Full capture:** `sw`=0x3, press `btn[0]`; `sw`=0x5, press; `sw`=0xA, press → `op`=3, `opa`=5, `opb`=A, `state`=3. `go` is high exactly one cycle, at edge 6 after the third press's raw rise.
- **Bounce rejection:** `btn[0]` toggles high/low every 2 cycles for 20 cycles, then stays low → no state change, `go` never asserts. Holding high for 6 cycles afterwards → exactly one advance.
- **Clear priority:** in `S_B`, press `btn[0]` and `btn[1]` on the same cycle → `state`=0, all fields 0, `go`=0.
- **Display cycling:** after the full capture, press `btn[2]` five times → `led` sequence 3, 5, A, `sw`, 3. `sel` wraps 3→0.
- **Re-fire and held button:** in `S_READY`, hold `btn[0]` for 50 cycles → one `go` only. Release and press again → a second `go`, fields unchanged.
- **Reset mid-capture:** in `S_A` with `op`=3, assert `reset` one cycle while `btn[0]` is held → all outputs 0 next cycle. One press is seen after debounce, giving `op`=current `sw` and `state`=1.
